nts_rx_copy_engine: RTL and testbench

// Parametrised successor of the single-state-machine rx engine. Copies one packet from the

---
 rtl/nts_rx_copy_engine.sv | 188 ++++++++++++++++++
 tb/tb_nts_rx_copy_engine.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/nts_rx_copy_engine.sv
// RX copy engine: moves one dispatcher packet into a local 64-bit RAM, reports its length,
// and holds it for the parser; oversize or badly-masked packets are drained and counted.
module nts_rx_copy_engine #(
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    i_clk,
    input  logic                    i_areset,
    output logic                    o_busy,
    input  logic                    i_dispatch_packet_available,
    output logic                    o_dispatch_packet_read_discard,
    input  logic [7:0]              i_dispatch_data_valid,
    input  logic                    i_dispatch_fifo_empty,
    output logic                    o_dispatch_fifo_rd_en,
    input  logic [63:0]             i_dispatch_fifo_rd_data,
    output logic                    o_packet_valid,
    output logic [ADDR_WIDTH:0]     o_packet_words,
    output logic [ADDR_WIDTH+3:0]   o_packet_bytes,
    input  logic                    i_packet_done,
    input  logic [ADDR_WIDTH-1:0]   i_ram_rd_addr,
    output logic [63:0]             o_ram_rd_data,
    input  logic                    i_counter_clear,
    output logic [CNT_WIDTH-1:0]    o_cnt_packets,
    output logic [CNT_WIDTH-1:0]    o_cnt_overflow,
    output logic [CNT_WIDTH-1:0]    o_cnt_bad
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_COPY, S_FINISH, S_READY, S_DRAIN} state_t;

    state_t                 r_state, w_next;
    logic [ADDR_WIDTH:0]    r_wr_ptr;
    logic                   r_capture;
    logic [63:0]            r_ram [DEPTH];
    logic [63:0]            r_ram_rd_data;
    logic                   r_valid;
    logic [ADDR_WIDTH:0]    r_words;
    logic [ADDR_WIDTH+3:0]  r_bytes;
    logic [CNT_WIDTH-1:0]   r_cnt_packets, r_cnt_overflow, r_cnt_bad;

    logic                   w_rd_en, w_discard, w_accept;
    logic                   w_inc_packets, w_inc_overflow, w_inc_bad;
    logic                   w_write, w_mask_legal;
    logic [3:0]             w_mask_k;
    logic [ADDR_WIDTH:0]    w_captured;
    logic [ADDR_WIDTH+3:0]  w_bytes;

    // Only COPY writes; words arriving from reads issued in DRAIN are dropped.
    assign w_write    = (r_state == S_COPY) && r_capture;
    assign w_captured = r_wr_ptr + {{ADDR_WIDTH{1'b0}}, r_capture};
    assign w_bytes    = {r_wr_ptr - 1'b1, 3'b000} + {{ADDR_WIDTH{1'b0}}, w_mask_k};

    always_comb begin
        w_mask_k     = '0;
        w_mask_legal = 1'b1;
        case (i_dispatch_data_valid)
            8'h01:   w_mask_k = 4'd1;
            8'h03:   w_mask_k = 4'd2;
            8'h07:   w_mask_k = 4'd3;
            8'h0f:   w_mask_k = 4'd4;
            8'h1f:   w_mask_k = 4'd5;
            8'h3f:   w_mask_k = 4'd6;
            8'h7f:   w_mask_k = 4'd7;
            8'hff:   w_mask_k = 4'd8;
            default: w_mask_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next         = r_state;
        w_rd_en        = 1'b0;
        w_discard      = 1'b0;
        w_accept       = 1'b0;
        w_inc_packets  = 1'b0;
        w_inc_overflow = 1'b0;
        w_inc_bad      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_dispatch_packet_available && !i_dispatch_fifo_empty) begin
                    w_rd_en = 1'b1;
                    w_next  = S_COPY;
                end
            end
            S_COPY: begin
                if (i_dispatch_fifo_empty) begin
                    w_next = S_FINISH;
                end else if (w_captured < DEPTH_W) begin
                    w_rd_en = 1'b1;
                end else begin
                    w_next = S_DRAIN;
                end
            end
            S_FINISH: begin
                if (w_mask_legal) begin
                    w_accept = 1'b1;
                    w_next   = S_READY;
                end else begin
                    w_discard = 1'b1;
                    w_inc_bad = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_READY: begin
                if (i_packet_done) begin
                    w_discard     = 1'b1;
                    w_inc_packets = 1'b1;
                    w_next        = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (i_dispatch_fifo_empty) begin
                    w_discard      = 1'b1;
                    w_inc_overflow = 1'b1;
                    w_next         = S_IDLE;
                end else begin
                    w_rd_en = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            r_state   <= S_IDLE;
            r_wr_ptr  <= '0;
            r_capture <= 1'b0;
            r_valid   <= 1'b0;
            r_words   <= '0;
            r_bytes   <= '0;
        end else begin
            r_state   <= w_next;
            r_capture <= w_rd_en;
            if (r_state == S_IDLE) begin
                r_wr_ptr <= '0;
            end else if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_accept) begin
                r_valid <= 1'b1;
                r_words <= r_wr_ptr;
                r_bytes <= w_bytes;
            end else if (w_inc_packets) begin
                r_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_areset || i_counter_clear) begin
            r_cnt_packets  <= '0;
            r_cnt_overflow <= '0;
            r_cnt_bad      <= '0;
        end else begin
            if (w_inc_packets)  r_cnt_packets  <= r_cnt_packets + 1'b1;
            if (w_inc_overflow) r_cnt_overflow <= r_cnt_overflow + 1'b1;
            if (w_inc_bad)      r_cnt_bad      <= r_cnt_bad + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_write) begin
            r_ram[r_wr_ptr[ADDR_WIDTH-1:0]] <= i_dispatch_fifo_rd_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            r_ram_rd_data <= '0;
        end else begin
            r_ram_rd_data <= r_ram[i_ram_rd_addr];
        end
    end

    assign o_busy                         = (r_state != S_IDLE);
    assign o_dispatch_packet_read_discard = w_discard;
    assign o_dispatch_fifo_rd_en          = w_rd_en;
    assign o_packet_valid                 = r_valid;
    assign o_packet_words                 = r_words;
    assign o_packet_bytes                 = r_bytes;
    assign o_ram_rd_data                  = r_ram_rd_data;
    assign o_cnt_packets                  = r_cnt_packets;
    assign o_cnt_overflow                 = r_cnt_overflow;
    assign o_cnt_bad                      = r_cnt_bad;

endmodule

// File: tb/tb_nts_rx_copy_engine.sv
// Bench for nts_rx_copy_engine: dispatcher FIFO model plus an outcome scoreboard per packet.
module tb_nts_rx_copy_engine;

    localparam int AW    = 3;
    localparam int CW    = 32;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            busy;
    logic            avail;
    logic            discard;
    logic [7:0]      mask;
    logic            fifo_empty = 1'b1;
    logic            rd_en;
    logic [63:0]     rd_data = '0;
    logic            pvalid;
    logic [AW:0]     pwords;
    logic [AW+3:0]   pbytes;
    logic            done;
    logic [AW-1:0]   raddr;
    logic [63:0]     rdata;
    logic            cclr;
    logic [CW-1:0]   cnt_p, cnt_o, cnt_b;

    always #5 clk = ~clk;

    nts_rx_copy_engine #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .i_clk                          (clk),
        .i_areset                       (rst),
        .o_busy                         (busy),
        .i_dispatch_packet_available    (avail),
        .o_dispatch_packet_read_discard (discard),
        .i_dispatch_data_valid          (mask),
        .i_dispatch_fifo_empty          (fifo_empty),
        .o_dispatch_fifo_rd_en          (rd_en),
        .i_dispatch_fifo_rd_data        (rd_data),
        .o_packet_valid                 (pvalid),
        .o_packet_words                 (pwords),
        .o_packet_bytes                 (pbytes),
        .i_packet_done                  (done),
        .i_ram_rd_addr                  (raddr),
        .o_ram_rd_data                  (rdata),
        .i_counter_clear                (cclr),
        .o_cnt_packets                  (cnt_p),
        .o_cnt_overflow                 (cnt_o),
        .o_cnt_bad                      (cnt_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Dispatcher FIFO: read data appears the cycle after rd_en, empty reflects the pop.
    logic [63:0] fq[$];
    always @(posedge clk) begin
        if (rd_en && fq.size() > 0) rd_data <= fq.pop_front();
        fifo_empty <= (fq.size() == 0);
    end

    typedef struct {
        int kind;   // 0 accepted, 1 overflow, 2 bad mask
        int words;
        int bytes;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] exp_ram [DEPTH];
    int unsigned exp_p = 0, exp_o = 0, exp_b = 0;

    function automatic int mask_k(input logic [7:0] m);
        for (int k = 1; k <= 8; k++) begin
            if (m == 8'((1 << k) - 1)) return k;
        end
        return 0;
    endfunction

    task automatic send(input int n, input logic [7:0] m);
        exp_t e;
        int   k;
        logic [63:0] w;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom};
            fq.push_back(w);
            if (i < DEPTH) exp_ram[i] = w;
        end
        mask = m;
        k = mask_k(m);
        e.words = 0;
        e.bytes = 0;
        if (n > DEPTH)   e.kind = 1;
        else if (k == 0) e.kind = 2;
        else begin
            e.kind  = 0;
            e.words = n;
            e.bytes = (n - 1) * 8 + k;
        end
        sb.push_back(e);
        @(negedge clk);
        avail = 1'b1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_cnt_packets"},  64'(cnt_p), 64'(exp_p));
        check({tag, "_cnt_overflow"}, 64'(cnt_o), 64'(exp_o));
        check({tag, "_cnt_bad"},      64'(cnt_b), 64'(exp_b));
    endtask

    task automatic process(input string tag, input logic clr_on_done);
        exp_t e;
        int   cyc = 0;
        while (!pvalid && !discard && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 300) begin
            check({tag, "_outcome_timeout"}, 64'(1), 64'(0));
            avail = 1'b0;
            fq.delete();
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        check({tag, "_accepted"}, 64'(pvalid), 64'(e.kind == 0));
        if (pvalid) begin
            check({tag, "_words"}, 64'(pwords), 64'(e.words));
            check({tag, "_bytes"}, 64'(pbytes), 64'(e.bytes));
            for (int i = 0; i < int'(pwords) && i < DEPTH; i++) begin
                raddr = AW'(i);
                @(negedge clk);
                check($sformatf("%s_ram%0d", tag, i), rdata, exp_ram[i]);
            end
            check({tag, "_valid_held"}, 64'(pvalid), 64'(1));
            done  = 1'b1;
            cclr  = clr_on_done;
            avail = 1'b0;
            #1;
            check({tag, "_done_discard"}, 64'(discard), 64'(1));
            @(negedge clk);
            done = 1'b0;
            cclr = 1'b0;
            if (clr_on_done) begin
                exp_p = 0; exp_o = 0; exp_b = 0;
            end else begin
                exp_p++;
            end
            check({tag, "_valid_cleared"}, 64'(pvalid), 64'(0));
        end else begin
            avail = 1'b0;
            if (e.kind == 1) exp_o++;
            if (e.kind == 2) exp_b++;
            @(negedge clk);
        end
        check({tag, "_pulse_width"}, 64'(discard), 64'(0));
        check({tag, "_idle"}, 64'(busy), 64'(0));
        check_counters(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        avail = 1'b0;
        mask  = 8'h00;
        done  = 1'b0;
        raddr = '0;
        cclr  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",   64'(busy),   64'(0));
        check("rst_valid",  64'(pvalid), 64'(0));
        check("rst_rd_en",  64'(rd_en),  64'(0));
        check("rst_words",  64'(pwords), 64'(0));
        check("rst_bytes",  64'(pbytes), 64'(0));
        check("rst_rdata",  rdata,       64'(0));
        check_counters("rst");
        rst = 1'b0;

        send(5, 8'h0f);  process("five_0f", 1'b0);
        send(1, 8'hff);  process("one_ff", 1'b0);
        send(9, 8'hff);  process("ovf9", 1'b0);
        send(8, 8'hff);  process("full8", 1'b0);
        send(2, 8'h00);  process("mask00", 1'b0);
        send(2, 8'h05);  process("mask05", 1'b0);
        send(3, 8'h01);  process("mask01", 1'b0);
        send(2, 8'h03);  process("clr_done", 1'b1);

        // Spurious done while idle must not pulse discard or count.
        @(negedge clk);
        done = 1'b1;
        #1;
        check("idle_done_discard", 64'(discard), 64'(0));
        @(negedge clk);
        done = 1'b0;
        check("idle_done_busy", 64'(busy), 64'(0));
        check_counters("idle_done");

        // Seed counters, then abort a copy mid-packet with reset.
        send(2, 8'h00);  process("pre_rst_bad", 1'b0);
        send(6, 8'hff);
        void'(sb.pop_back());
        for (int c = 0; c < 50 && !busy; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("mid_copy_busy", 64'(busy), 64'(1));
        rst   = 1'b1;
        avail = 1'b0;
        fq.delete();
        @(negedge clk);
        exp_p = 0; exp_o = 0; exp_b = 0;
        check("abort_busy",    64'(busy),    64'(0));
        check("abort_discard", 64'(discard), 64'(0));
        check("abort_rd_en",   64'(rd_en),   64'(0));
        check("abort_valid",   64'(pvalid),  64'(0));
        check("abort_words",   64'(pwords),  64'(0));
        check("abort_bytes",   64'(pbytes),  64'(0));
        check_counters("abort");
        @(negedge clk);
        rst = 1'b0;
        send(4, 8'h3f);  process("after_rst", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
